mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Dual-port storage shared by NUM_CH requestors; round-robin grants up to two channels per cycle.
// Define MEM_INIT_SWEEP_EN to fill storage with INIT_WORD after every reset before arbitration starts.
module mem_arbiter #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 18,
    parameter int NUM_CH = 4,
    parameter logic [DATA_W-1:0] INIT_WORD = 24'hFFFFFF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*DATA_W-1:0] req_wdata,
    output logic [NUM_CH-1:0]        rsp_valid,
    output logic [NUM_CH*DATA_W-1:0] rsp_rdata,
    output logic                     busy
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_SWEEP = 1'b0, ST_RUN = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rr_q, rr_d;

    logic [ADDR_W-1:0] ch_addr  [NUM_CH];
    logic [DATA_W-1:0] ch_wdata [NUM_CH];
    logic [DATA_W-1:0] ch_rdata [NUM_CH];
    logic [DATA_W-1:0] hold_q   [NUM_CH];

    logic              a_found, b_found;
    logic [PTR_W-1:0]  a_idx, b_idx, cand;
    logic              a_we, b_we, collide, run, gnt_a, gnt_b;

    logic              mem_we_a, mem_we_b;
    logic [ADDR_W-1:0] mem_addr_a, mem_addr_b;
    logic [DATA_W-1:0] mem_wdata_a, mem_wdata_b;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_a_data_q, rd_b_data_q;
    logic              rd_a_vld_q, rd_b_vld_q;
    logic [PTR_W-1:0]  rd_a_ch_q, rd_b_ch_q;

`ifdef MEM_INIT_SWEEP_EN
    logic [ADDR_W-2:0] sweep_q, sweep_d;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign ch_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign ch_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign rsp_rdata[gi*DATA_W +: DATA_W] = ch_rdata[gi];
        end
    endgenerate

    // Port A takes the first requester at/after rr_q; port B the next one after A.
    always_comb begin
        a_found = 1'b0;
        a_idx   = '0;
        b_found = 1'b0;
        b_idx   = '0;
        cand    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = PTR_W'((int'(rr_q) + k) % NUM_CH);
            if (!a_found && req_valid[cand]) begin
                a_found = 1'b1;
                a_idx   = cand;
            end
        end
        for (int k = 1; k < NUM_CH; k++) begin
            cand = PTR_W'((int'(a_idx) + k) % NUM_CH);
            if (a_found && !b_found && req_valid[cand]) begin
                b_found = 1'b1;
                b_idx   = cand;
            end
        end
    end

    assign a_we    = req_we[a_idx];
    assign b_we    = req_we[b_idx];
    assign collide = a_found && b_found && (ch_addr[a_idx] == ch_addr[b_idx]) && (a_we || b_we);
    assign run     = (state_q == ST_RUN) && !reset;
    assign gnt_a   = run && a_found;
    assign gnt_b   = run && b_found && !collide;

    always_comb begin
        req_ready = '0;
        if (gnt_a) req_ready[a_idx] = 1'b1;
        if (gnt_b) req_ready[b_idx] = 1'b1;
    end

    // B always lies after A in circular order, so it is the last grant when present.
    always_comb begin
        rr_d = rr_q;
        if (gnt_b)
            rr_d = (b_idx == PTR_W'(NUM_CH - 1)) ? '0 : b_idx + 1'b1;
        else if (gnt_a)
            rr_d = (a_idx == PTR_W'(NUM_CH - 1)) ? '0 : a_idx + 1'b1;
    end

    always_comb begin
        mem_we_a    = gnt_a && a_we;
        mem_addr_a  = ch_addr[a_idx];
        mem_wdata_a = ch_wdata[a_idx];
        mem_we_b    = gnt_b && b_we;
        mem_addr_b  = ch_addr[b_idx];
        mem_wdata_b = ch_wdata[b_idx];
`ifdef MEM_INIT_SWEEP_EN
        if (state_q == ST_SWEEP) begin
            mem_we_a    = !reset;
            mem_addr_a  = {sweep_q, 1'b0};
            mem_wdata_a = INIT_WORD;
            mem_we_b    = !reset;
            mem_addr_b  = {sweep_q, 1'b1};
            mem_wdata_b = INIT_WORD;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
`ifdef MEM_INIT_SWEEP_EN
        sweep_d = sweep_q;
`endif
        case (state_q)
            ST_SWEEP: begin
`ifdef MEM_INIT_SWEEP_EN
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == '1) state_d = ST_RUN;
`else
                state_d = ST_RUN;
`endif
            end
            default: state_d = ST_RUN;
        endcase
    end

`ifdef MEM_INIT_SWEEP_EN
    assign busy = (state_q == ST_SWEEP) && !reset;

    always_ff @(posedge clock) begin
        if (reset) sweep_q <= '0;
        else       sweep_q <= sweep_d;
    end
`else
    assign busy = 1'b0;
`endif

    // Collisions are never granted together, so same-address read/write in one cycle cannot occur.
    always_ff @(posedge clock) begin
        if (mem_we_a) mem_q[mem_addr_a] <= mem_wdata_a;
        if (mem_we_b) mem_q[mem_addr_b] <= mem_wdata_b;
        rd_a_data_q <= mem_q[mem_addr_a];
        rd_b_data_q <= mem_q[mem_addr_b];
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            rsp_valid[k] = (rd_a_vld_q && rd_a_ch_q == PTR_W'(k)) ||
                           (rd_b_vld_q && rd_b_ch_q == PTR_W'(k));
            if (rd_a_vld_q && rd_a_ch_q == PTR_W'(k))
                ch_rdata[k] = rd_a_data_q;
            else if (rd_b_vld_q && rd_b_ch_q == PTR_W'(k))
                ch_rdata[k] = rd_b_data_q;
            else
                ch_rdata[k] = hold_q[k];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_SWEEP;
            rr_q       <= '0;
            rd_a_vld_q <= 1'b0;
            rd_b_vld_q <= 1'b0;
            rd_a_ch_q  <= '0;
            rd_b_ch_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) hold_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            rd_a_vld_q <= gnt_a && !a_we;
            rd_b_vld_q <= gnt_b && !b_we;
            rd_a_ch_q  <= a_idx;
            rd_b_ch_q  <= b_idx;
            for (int k = 0; k < NUM_CH; k++)
                if (rsp_valid[k]) hold_q[k] <= ch_rdata[k];
        end
    end

endmodule
